// File: rtl/ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : ctrl_pkg                                                   |
// | Description : Shared definitions for the per-stage control bundle        |
// |               (op, funct3, rd) and the elastic stage state encoding.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package ctrl_pkg;

   // Default field widths of the control bundle
   localparam int CTRL_OP_W = 5;
   localparam int CTRL_F3_W = 3;
   localparam int CTRL_RD_W = 5;

   // Control bundle at default widths; field order matches the packed storage
   // layout used inside the stage: {op, f3, rd}.
   typedef struct packed {
      logic [CTRL_OP_W-1:0] op;
      logic [CTRL_F3_W-1:0] f3;
      logic [CTRL_RD_W-1:0] rd;
   } ctrl_bundle_t;

   // Stage occupancy encoding: bit 0 = main entry valid, bit 1 = skid entry valid
   localparam logic [1:0] ST_EMPTY = 2'b00;
   localparam logic [1:0] ST_ONE   = 2'b01;
   localparam logic [1:0] ST_TWO   = 2'b11;

   // The stage has room for one more bundle unless both entries are occupied
   function automatic logic st_has_room(input logic [1:0] st);
      return (st != ST_TWO);
   endfunction

endpackage : ctrl_pkg
`default_nettype wire

// File: rtl/ctrl_pipe_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ctrl_pipe_stage                                            |
// | Description : 2-entry elastic (skid) pipeline register for the control   |
// |               bundle {op, funct3, rd}. Registered in_ready, no input-to- |
// |               output combinational path, synchronous flush, and field    |
// |               zeroing on out_* whenever out_valid is low.                |
// |               Optional macro CTRL_STAGE_STALL_CNT_EN adds a saturating   |
// |               32-bit stall counter on port stall_cnt.                    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module ctrl_pipe_stage
   import ctrl_pkg::*;
#(
   parameter int OP_W = CTRL_OP_W,
   parameter int F3_W = CTRL_F3_W,
   parameter int RD_W = CTRL_RD_W
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [OP_W-1:0] in_op,
   input  logic [F3_W-1:0] in_f3,
   input  logic [RD_W-1:0] in_rd,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [OP_W-1:0] out_op,
   output logic [F3_W-1:0] out_f3,
   output logic [RD_W-1:0] out_rd
`ifdef CTRL_STAGE_STALL_CNT_EN
   ,
   output logic [31:0]     stall_cnt
`endif
);

   // Packed bundle width: {op, f3, rd}
   localparam int BUN_W = OP_W + F3_W + RD_W;

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [BUN_W-1:0] main_q;
   logic [BUN_W-1:0] skid_q;
   logic [BUN_W-1:0] in_bundle;
   logic             in_ready_q;
   logic             accept;
   logic             drain;
   logic             load_main_in;
   logic             load_main_skid;
   logic             load_skid;

   assign in_bundle = {in_op, in_f3, in_rd};

   // Main entry drives the output, so the stage presents data whenever it is occupied
   assign out_valid = (state != ST_EMPTY);
   assign in_ready  = in_ready_q;
   assign accept    = in_valid & in_ready_q;
   assign drain     = out_valid & out_ready;

   // Next-state and load-enable decode; flush overrides every handshake
   always_comb begin
      state_nxt      = state;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      if (flush) begin
         state_nxt = ST_EMPTY;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (accept) begin
                  state_nxt    = ST_ONE;
                  load_main_in = 1'b1;
               end
            end
            ST_ONE: begin
               if (accept && drain) begin
                  load_main_in = 1'b1;
               end else if (drain) begin
                  state_nxt = ST_EMPTY;
               end else if (accept) begin
                  state_nxt = ST_TWO;
                  load_skid = 1'b1;
               end
            end
            ST_TWO: begin
               // in_ready is low here, so no accept can coincide with the drain
               if (drain) begin
                  state_nxt      = ST_ONE;
                  load_main_skid = 1'b1;
               end
            end
            default: begin
               // Unused encoding 2'b10: recover to a clean empty stage
               state_nxt = ST_EMPTY;
            end
         endcase
      end
   end

   // Occupancy state and registered in_ready, both derived from the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_EMPTY;
         in_ready_q <= 1'b1;
      end else begin
         state      <= state_nxt;
         in_ready_q <= st_has_room(state_nxt);
      end
   end

   // Bundle storage: main takes fresh input or the skidded entry, skid takes input on overflow
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_q <= '0;
         skid_q <= '0;
      end else begin
         if (load_main_in) begin
            main_q <= in_bundle;
         end else if (load_main_skid) begin
            main_q <= skid_q;
         end
         if (load_skid) begin
            skid_q <= in_bundle;
         end
      end
   end

   // Zero the fields while idle: downstream hazard logic treats rd=0 as "no write"
   assign out_op = out_valid ? main_q[BUN_W-1 -: OP_W] : '0;
   assign out_f3 = out_valid ? main_q[RD_W +: F3_W]    : '0;
   assign out_rd = out_valid ? main_q[RD_W-1:0]        : '0;

`ifdef CTRL_STAGE_STALL_CNT_EN
   logic [31:0] stall_cnt_q;

   // Count cycles where downstream back-pressures a valid bundle; saturating, reset only by rst_n
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
      end else if (out_valid && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule : ctrl_pipe_stage
`default_nettype wire
